// File: rtl/md_unit_pkg.sv
// md_unit_pkg: md op codes and decode helpers shared by md_unit.
// Optional MD_MADD_EN adds madd/maddu/msub/msubu decode.
`ifndef MD_UNIT_DEFS
`define MD_UNIT_DEFS
`define MD_NONE  4'd0
`define MD_MULT  4'd1
`define MD_MULTU 4'd2
`define MD_DIV   4'd3
`define MD_DIVU  4'd4
`define MD_MTHI  4'd5
`define MD_MTLO  4'd6
`define MD_MADD  4'd7
`define MD_MADDU 4'd8
`define MD_MSUB  4'd9
`define MD_MSUBU 4'd10
`endif

package md_unit_pkg;

  function automatic logic md_is_div(
    input logic [3:0] op
  );
    return (op == `MD_DIV) || (op == `MD_DIVU);
  endfunction

  function automatic logic md_is_mul(
    input logic [3:0] op
  );
    logic r;
    r = (op == `MD_MULT) || (op == `MD_MULTU);
`ifdef MD_MADD_EN
    r = r || (op == `MD_MADD) || (op == `MD_MADDU)
          || (op == `MD_MSUB) || (op == `MD_MSUBU);
`endif
    return r;
  endfunction

  function automatic logic md_is_long(
    input logic [3:0] op
  );
    return md_is_mul(op) || md_is_div(op);
  endfunction

endpackage

// File: rtl/md_calc.sv
// md_calc: combinational 64-bit result for mult/div class ops.
// MD_MADD_EN adds accumulate forms against the current {HI,LO}.
import md_unit_pkg::*;

module md_calc (
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [31:0] hi_n,
  output logic [31:0] lo_n
);

  logic [63:0] pu;
  logic [63:0] ps;
  logic [31:0] ma;
  logic [31:0] mb;
  logic [31:0] uq;
  logic [31:0] ur;
  logic [31:0] sq_m;
  logic [31:0] sr_m;
  logic [31:0] sq;
  logic [31:0] sr;
  logic [63:0] res;

  always_comb begin
    pu   = {32'd0, a} * {32'd0, b};
    // low 64 bits of sign-extended operands give the signed product
    ps   = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    ma   = a[31] ? 32'd0 - a : a;
    mb   = b[31] ? 32'd0 - b : b;
    uq   = (b == 32'd0) ? 32'd0 : a / b;
    ur   = (b == 32'd0) ? 32'd0 : a % b;
    sq_m = (mb == 32'd0) ? 32'd0 : ma / mb;
    sr_m = (mb == 32'd0) ? 32'd0 : ma % mb;
    sq   = (a[31] ^ b[31]) ? 32'd0 - sq_m : sq_m;
    sr   = a[31] ? 32'd0 - sr_m : sr_m;
    res  = {hi, lo};
    case (op)
      `MD_MULT:  res = ps;
      `MD_MULTU: res = pu;
      `MD_DIV:   if (b != 32'd0) res = {sr, sq};
      `MD_DIVU:  if (b != 32'd0) res = {ur, uq};
`ifdef MD_MADD_EN
      `MD_MADD:  res = {hi, lo} + ps;
      `MD_MADDU: res = {hi, lo} + pu;
      `MD_MSUB:  res = {hi, lo} - ps;
      `MD_MSUBU: res = {hi, lo} - pu;
`endif
      default:   res = {hi, lo};
    endcase
    hi_n = res[63:32];
    lo_n = res[31:0];
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit holding HI/LO.
// Define MD_MADD_EN to enable madd/maddu/msub/msubu.
import md_unit_pkg::*;

module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        req,
  input  logic        rd_hi,
  output logic        busy,
  output logic        start,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] md_out
);

  localparam int MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  logic [CW-1:0] cnt;
  logic [31:0]   hi_n;
  logic [31:0]   lo_n;
  logic [31:0]   hi_c;
  logic [31:0]   lo_c;
  logic          accept;

  md_calc u_calc (
    .op   (md_op),
    .a    (A),
    .b    (B),
    .hi   (HI),
    .lo   (LO),
    .hi_n (hi_c),
    .lo_n (lo_c)
  );

  assign accept = (md_op != `MD_NONE) && !busy
               && !req && !reset;
  assign start  = accept && md_is_long(md_op);
  assign md_out = rd_hi ? HI : LO;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy <= 1'b0;
      cnt  <= '0;
      HI   <= '0;
      LO   <= '0;
      hi_n <= '0;
      lo_n <= '0;
    end else if (busy) begin
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        busy <= 1'b0;
        HI   <= hi_n;
        LO   <= lo_n;
      end
    end else if (start) begin
      busy <= 1'b1;
      hi_n <= hi_c;
      lo_n <= lo_c;
      cnt  <= md_is_div(md_op) ? CW'(DIV_CYCLES)
                               : CW'(MULT_CYCLES);
    end else if (accept) begin
      if (md_op == `MD_MTHI) HI <= A;
      if (md_op == `MD_MTLO) LO <= A;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed vector bench for md_unit.
// Honours MD_MADD_EN for the accumulate check.
module tb_md_unit;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        req = 1'b0;
  logic        rd_hi = 1'b0;
  logic        busy;
  logic        start;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] md_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vt[10];

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .md_op  (md_op),
    .A      (A),
    .B      (B),
    .req    (req),
    .rd_hi  (rd_hi),
    .busy   (busy),
    .start  (start),
    .HI     (HI),
    .LO     (LO),
    .md_out (md_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (busy && md_op != OP_NONE) begin
      errors++;
      $display("FAIL op_while_busy actual=%0d required=0", md_op);
    end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int n;
    @(negedge clk);
    md_op = v.op;
    A = v.a;
    B = v.b;
    #1;
    chk({nm, ".start"}, 64'(start), 64'(v.cyc != 0));
    @(posedge clk);
    #1;
    md_op = OP_NONE;
    @(negedge clk);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk({nm, ".busy_cyc"}, 64'(n), 64'(v.cyc));
    chk({nm, ".hi"}, 64'(HI), 64'(v.hi));
    chk({nm, ".lo"}, 64'(LO), 64'(v.lo));
  endtask

  task automatic do_op(input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo,
                       input int cyc, input string nm);
    vec_t v;
    v = '{op: op, a: a, b: b, hi: hi, lo: lo, cyc: cyc};
    run_vec(v, nm);
  endtask

  initial begin
    int n;
    vt[0] = '{OP_MULT,  32'hFFFFFFFF, 32'd2,
              32'hFFFFFFFF, 32'hFFFFFFFE, 5};
    vt[1] = '{OP_MULTU, 32'hFFFFFFFF, 32'd2,
              32'h00000001, 32'hFFFFFFFE, 5};
    vt[2] = '{OP_DIV,   32'hFFFFFFF9, 32'd2,
              32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vt[3] = '{OP_DIVU,  32'd7, 32'd2, 32'd1, 32'd3, 10};
    vt[4] = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF,
              32'd0, 32'h80000000, 10};
    vt[5] = '{OP_MULT,  32'h80000000, 32'h80000000,
              32'h40000000, 32'd0, 5};
    vt[6] = '{OP_DIV,   32'hFFFFFFF9, 32'hFFFFFFFE,
              32'hFFFFFFFF, 32'd3, 10};
    vt[7] = '{OP_MTHI,  32'h11, 32'd0, 32'h11, 32'd3, 0};
    vt[8] = '{OP_MTLO,  32'h22, 32'd0, 32'h11, 32'h22, 0};
    vt[9] = '{OP_DIV,   32'd5, 32'd0, 32'h11, 32'h22, 10};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.hi", 64'(HI), 64'd0);
    chk("rst.lo", 64'(LO), 64'd0);

    for (int i = 0; i < 10; i++)
      run_vec(vt[i], $sformatf("vec%0d", i));

    rd_hi = 1'b1;
    #1;
    chk("md_out.hi", 64'(md_out), 64'h11);
    rd_hi = 1'b0;
    #1;
    chk("md_out.lo", 64'(md_out), 64'h22);

    // flushed ops must leave HI/LO alone
    @(negedge clk);
    md_op = OP_MULT;
    A = 32'd3;
    B = 32'd4;
    req = 1'b1;
    #1;
    chk("req_mult.start", 64'(start), 64'd0);
    @(posedge clk);
    #1;
    md_op = OP_MTLO;
    A = 32'h99;
    @(posedge clk);
    #1;
    md_op = OP_NONE;
    req = 1'b0;
    @(negedge clk);
    chk("req.busy", 64'(busy), 64'd0);
    chk("req.hi", 64'(HI), 64'h11);
    chk("req.lo", 64'(LO), 64'h22);

    // in-flight op still commits when req arrives later
    @(negedge clk);
    md_op = OP_MULT;
    A = 32'd3;
    B = 32'd4;
    @(posedge clk);
    #1;
    md_op = OP_NONE;
    req = 1'b1;
    @(negedge clk);
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    req = 1'b0;
    chk("inflight.cyc", 64'(n), 64'd5);
    chk("inflight.hi", 64'(HI), 64'd0);
    chk("inflight.lo", 64'(LO), 64'd12);

    do_op(OP_MTHI, 32'd0, 32'd0, 32'd0, 32'd12, 0, "pre_hi");
    do_op(OP_MTLO, 32'hFFFFFFFF, 32'd0,
          32'd0, 32'hFFFFFFFF, 0, "pre_lo");
`ifdef MD_MADD_EN
    do_op(OP_MADDU, 32'd1, 32'd1, 32'd1, 32'd0, 5, "maddu");
`else
    do_op(OP_MADDU, 32'd1, 32'd1,
          32'd0, 32'hFFFFFFFF, 0, "maddu_off");
`endif

    // reset in busy cycle 4 aborts the divide
    @(negedge clk);
    md_op = OP_DIVU;
    A = 32'd100;
    B = 32'd7;
    @(posedge clk);
    #1;
    md_op = OP_NONE;
    repeat (4) @(negedge clk);
    chk("abort.busy_pre", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort.busy", 64'(busy), 64'd0);
    chk("abort.hi", 64'(HI), 64'd0);
    chk("abort.lo", 64'(LO), 64'd0);
    repeat (12) @(negedge clk);
    chk("abort.hi_late", 64'(HI), 64'd0);
    chk("abort.lo_late", 64'(LO), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
Multiply/divide unit in the E stage of the five-stage MIPS pipeline. It executes mult/multu/div/divu/mthi/mtlo, holds the architectural HI/LO registers, and serves mfhi/mflo reads. It drives the `busy` signal that the hazard unit uses to stall md-class instructions in D. It also honours exception/interrupt flush (`req`) from CP0 so that a flushed E-stage instruction never alters HI/LO.

Parameters:
MULT_CYCLES, 5, number of busy cycles after a mult/multu start (at least 1)
DIV_CYCLES, 10, number of busy cycles after a div/divu start (at least 1)

Ports:
clk  input  1  pipeline clock
reset  input  1  synchronous, active-high reset
md_op  input  4  E-stage md operation code, from shared constants; 0 means none
A  input  32  forwarded rs value (E stage)
B  input  32  forwarded rt value (E stage)
req  input  1  exception/interrupt flush; suppresses the E-stage md_op in the same cycle
rd_hi  input  1  1 selects HI for the read port, 0 selects LO
busy  output  1  long operation in flight; goes to the hazard unit
start  output  1  a mult/div was accepted this cycle (combinational)
HI  output  32  architectural HI
LO  output  32  architectural LO
md_out  output  32  rd_hi ? HI : LO (combinational), used by mfhi/mflo

Behaviour:
- Reset: busy=0, HI=0, LO=0, counter=0. Any pending result is discarded. Reset in the middle of an operation aborts it, and HI/LO read 0 on the next cycle.
- Acceptance condition: accept = md_op!=0 && !busy && !req && !reset.
  - For a mult/div code: start = accept.
  - For mthi/mtlo: start = 0.
- mult/multu/div/divu accepted at edge t:
  - the 64-bit result is computed from A and B at that edge and held in the pending {hi_n, lo_n} registers;
  - counter loads MULT_CYCLES or DIV_CYCLES;
  - busy=1 from t+1.
- Each edge while busy, counter decrements. At the edge where counter==1, HI/LO take the pending values and busy=0 from that point. busy is high for exactly N cycles, and the new HI/LO are visible in the first cycle with busy=0.
- mthi/mtlo accepted: at the next edge HI=A or LO=A. No busy, and the other register is unchanged.
- md_op while busy: ignored. The hazard unit guarantees this never happens; the bench asserts that it does not.
- req=1: the same-cycle md_op is fully ignored. An operation already in flight continues to commit, because it belongs to an older, committed instruction.
- Arithmetic rules:
  - mult is signed 32x32 to 64; multu is unsigned.
  - div/divu: LO=quotient, HI=remainder.
  - Signed division truncates toward zero, and the remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divide by zero: busy for the full DIV_CYCLES, and HI/LO keep their previous values.
- md_out reflects the current architectural HI/LO only. There is no bypass of pending values: busy stalls any mfhi/mflo.

Optional Feature:
- Macro MD_MADD_EN.
- With the macro defined, md_op also decodes madd/maddu/msub/msubu: {HI,LO} ± the 64-bit product, signed or unsigned, wrapping modulo 2^64. These take MULT_CYCLES and use the HI/LO values captured at acceptance.
- Without the macro, those codes are treated as none: no start, no state change.

Decomposition:
- MD op codes (MD_NONE, MULT, MULTU, DIV, DIVU, MTHI, MTLO, MADD, MADDU, MSUB, MSUBU) go in the shared constants header as `defines. The cycle defaults are parameters, not defines.
- One natural sub-module: md_calc, a combinational 64-bit result generator (op, A, B, HI, LO to {hi_n, lo_n}) that includes the div-by-zero hold.

Test Plan:
- mult A=0xFFFFFFFF, B=2 → start=1 at t; busy=1 for t+1..t+5; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Repeat with multu → HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7), B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=2 → LO=3, HI=1. div A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- Preload HI=0x11, LO=0x22 via mthi/mtlo; next cycle md_out reads 0x11 (rd_hi=1) and 0x22 (rd_hi=0). Then div by 0 → busy for 10 cycles, HI/LO stay 0x11/0x22.
- mult with req=1 in the same cycle → start=0, busy stays 0, HI/LO unchanged. mtlo with req=1 → LO unchanged.
- div started, reset asserted at busy cycle 4 → the following cycle busy=0, HI=LO=0, and the result is never committed.
- With MD_MADD_EN defined: HI=0, LO=0xFFFFFFFF, then maddu A=1, B=1 → HI=1, LO=0. Without the macro, the same code → no busy and HI/LO unchanged.
